// File: rtl/memory_copy_engine.sv
// rtl/memory_copy_engine.sv - block-copy DMA engine driving the memory unit controls and shared bus
// Optional pattern-fill mode is compiled in when MEMCPY_FILL_EN is defined.
module memory_copy_engine #(
  parameter int MAX_BURST = 0
) (
  input  logic        clk,
  input  logic        r,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] src_seg,
  input  logic [15:0] dst_addr,
  input  logic [15:0] dst_seg,
  input  logic [15:0] len,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic        busy,
  output logic        done,
`ifdef MEMCPY_FILL_EN
  input  logic        fill,
  input  logic [15:0] fill_pattern,
`endif
  inout  wire  [15:0] bus,
  output logic        roe,
  output logic        rwe,
  output logic [15:0] addr,
  output logic [15:0] saddr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_YIELD = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] BURST_LIMIT = 16'(MAX_BURST);

  state_t      state_q, state_d;
  logic [15:0] src_off_q, src_off_d;
  logic [15:0] src_seg_q, src_seg_d;
  logic [15:0] dst_off_q, dst_off_d;
  logic [15:0] dst_seg_q, dst_seg_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] burst_q, burst_d;
  logic [15:0] hold_q, hold_d;
  logic        pend_q, pend_d;
  logic        fill_q, fill_d;
  logic [15:0] pat_q, pat_d;

  logic        fill_in;
  logic [15:0] pat_in;
  logic        bus_oe;

`ifdef MEMCPY_FILL_EN
  assign fill_in = fill;
  assign pat_in  = fill_pattern;
`else
  assign fill_in = 1'b0;
  assign pat_in  = 16'h0000;
`endif

  // Only an owned WRITE cycle puts data on the shared bus.
  assign bus  = bus_oe ? (fill_q ? pat_q : hold_q) : 16'hzzzz;
  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    src_off_d = src_off_q;
    src_seg_d = src_seg_q;
    dst_off_d = dst_off_q;
    dst_seg_d = dst_seg_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    bus_req   = 1'b0;
    done      = 1'b0;
    roe       = 1'b0;
    rwe       = 1'b0;
    bus_oe    = 1'b0;
    addr      = 16'h0000;
    saddr     = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != 16'h0000) begin
            src_off_d = src_addr;
            src_seg_d = src_seg;
            dst_off_d = dst_addr;
            dst_seg_d = dst_seg;
            len_d     = len;
            cnt_d     = 16'h0000;
            burst_d   = 16'h0000;
            pend_d    = 1'b0;
            fill_d    = fill_in;
            pat_d     = pat_in;
            state_d   = S_REQ;
          end else begin
            state_d   = S_DONE;
          end
        end
      end

      S_REQ: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          state_d = (pend_q || fill_q) ? S_WRITE : S_READ;
        end
      end

      S_READ: begin
        bus_req = 1'b1;
        addr    = src_off_q;
        saddr   = src_seg_q;
        roe     = bus_grant;
        if (bus_grant) begin
          hold_d  = bus;
          state_d = S_WRITE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WRITE: begin
        bus_req = 1'b1;
        addr    = dst_off_q;
        saddr   = dst_seg_q;
        rwe     = bus_grant;
        bus_oe  = bus_grant;
        if (bus_grant) begin
          src_off_d = src_off_q + 16'h0001;
          dst_off_d = dst_off_q + 16'h0001;
          cnt_d     = cnt_q + 16'h0001;
          burst_d   = burst_q + 16'h0001;
          pend_d    = 1'b0;
          if (cnt_d == len_q) begin
            state_d = S_DONE;
          end else if ((MAX_BURST != 0) && (burst_d == BURST_LIMIT)) begin
            state_d = S_YIELD;
          end else begin
            state_d = fill_q ? S_WRITE : S_READ;
          end
        end else begin
          // Lost the bus mid-write: the held word is replayed after regrant.
          pend_d  = 1'b1;
          state_d = S_REQ;
        end
      end

      S_YIELD: begin
        burst_d = 16'h0000;
        state_d = S_REQ;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q   <= S_IDLE;
      src_off_q <= 16'h0000;
      src_seg_q <= 16'h0000;
      dst_off_q <= 16'h0000;
      dst_seg_q <= 16'h0000;
      len_q     <= 16'h0000;
      cnt_q     <= 16'h0000;
      burst_q   <= 16'h0000;
      hold_q    <= 16'h0000;
      pend_q    <= 1'b0;
      fill_q    <= 1'b0;
      pat_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      src_off_q <= src_off_d;
      src_seg_q <= src_seg_d;
      dst_off_q <= dst_off_d;
      dst_seg_q <= dst_seg_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
    end
  end

endmodule

// File: tb/tb_memory_copy_engine.sv
// tb/tb_memory_copy_engine.sv - directed self-checking bench for memory_copy_engine
// Exercises fill mode as well when MEMCPY_FILL_EN is defined.
module tb_memory_copy_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r;
  logic        start_a, start_b;
  logic        grant_a, grant_b;
  logic [15:0] src_addr, src_seg, dst_addr, dst_seg, len;
  wire  [15:0] bus_a, bus_b;
  logic        bus_req_a, busy_a, done_a, roe_a, rwe_a;
  logic        bus_req_b, busy_b, done_b, roe_b, rwe_b;
  logic [15:0] addr_a, saddr_a, addr_b, saddr_b;
`ifdef MEMCPY_FILL_EN
  logic        fill;
  logic [15:0] fill_pattern;
`endif

  memory_copy_engine #(.MAX_BURST(0)) dut_a (
    .clk(clk), .r(r), .start(start_a),
    .src_addr(src_addr), .src_seg(src_seg), .dst_addr(dst_addr), .dst_seg(dst_seg), .len(len),
    .bus_req(bus_req_a), .bus_grant(grant_a), .busy(busy_a), .done(done_a),
`ifdef MEMCPY_FILL_EN
    .fill(fill), .fill_pattern(fill_pattern),
`endif
    .bus(bus_a), .roe(roe_a), .rwe(rwe_a), .addr(addr_a), .saddr(saddr_a)
  );

  memory_copy_engine #(.MAX_BURST(2)) dut_b (
    .clk(clk), .r(r), .start(start_b),
    .src_addr(src_addr), .src_seg(src_seg), .dst_addr(dst_addr), .dst_seg(dst_seg), .len(len),
    .bus_req(bus_req_b), .bus_grant(grant_b), .busy(busy_b), .done(done_b),
`ifdef MEMCPY_FILL_EN
    .fill(fill), .fill_pattern(fill_pattern),
`endif
    .bus(bus_b), .roe(roe_b), .rwe(rwe_b), .addr(addr_b), .saddr(saddr_b)
  );

  // Memory unit model for dut_a: 24-bit effective address, low 12 bits index the array.
  logic [15:0] mem [4096];
  int          wcnt [4096];
  logic        pre_we;
  logic [11:0] pre_idx;
  logic [15:0] pre_data;
  wire  [23:0] eff_a = {8'h00, addr_a} + {saddr_a, 8'h00};
  wire  [11:0] idx_a = eff_a[11:0];
  assign bus_a = roe_a ? mem[idx_a] : 16'hzzzz;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (rwe_a) begin
      mem[idx_a]  <= bus_a;
      wcnt[idx_a] <= wcnt[idx_a] + 1;
    end
  end

  // dut_b source data is a function of the address.
  wire [23:0] eff_b = {8'h00, addr_b} + {saddr_b, 8'h00};
  assign bus_b = roe_b ? {4'hB, eff_b[11:0]} : 16'hzzzz;

  logic mon_clr;
  int   n_breq, n_roe, n_rwe, n_bad, n_yield, nwr_b;
  int   y_at [4];

  always @(posedge clk) begin
    if (mon_clr) begin
      n_breq <= 0; n_roe <= 0; n_rwe <= 0; n_bad <= 0;
      n_yield <= 0; nwr_b <= 0;
      y_at[0] <= 0; y_at[1] <= 0; y_at[2] <= 0; y_at[3] <= 0;
    end else begin
      n_breq <= n_breq + int'(bus_req_a);
      n_roe  <= n_roe + int'(roe_a);
      n_rwe  <= n_rwe + int'(rwe_a);
      n_bad  <= n_bad + int'((roe_a && rwe_a) || ((roe_a || rwe_a) && !grant_a));
      nwr_b  <= nwr_b + int'(rwe_b);
      if (busy_b && !bus_req_b && !done_b) begin
        n_yield <= n_yield + 1;
        if (n_yield < 4) y_at[n_yield] <= nwr_b;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] idx, input logic [15:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic go_a(input logic [15:0] sa, input logic [15:0] ss, input logic [15:0] da,
                      input logic [15:0] ds, input logic [15:0] l);
    src_addr = sa; src_seg = ss; dst_addr = da; dst_seg = ds; len = l;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_a(output int lat, output int nbusy);
    lat = 1;
    nbusy = int'(busy_a);
    while (!done_a && lat < 200) begin
      tick();
      lat++;
      nbusy += int'(busy_a);
    end
    check("done_seen", {31'b0, done_a}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bus_req"}, {31'b0, bus_req_a}, 32'd0);
    check({tag, "_busy"},    {31'b0, busy_a},    32'd0);
    check({tag, "_done"},    {31'b0, done_a},    32'd0);
    check({tag, "_roe"},     {31'b0, roe_a},     32'd0);
    check({tag, "_rwe"},     {31'b0, rwe_a},     32'd0);
    check({tag, "_addr"},    {16'b0, addr_a},    32'd0);
    check({tag, "_saddr"},   {16'b0, saddr_a},   32'd0);
    check({tag, "_bus_oe"},  {31'b0, dut_a.bus_oe}, 32'd0);
  endtask

  int lat, nbusy, w0;

  initial begin
    r = 1'b1; start_a = 1'b0; start_b = 1'b0; grant_a = 1'b1; grant_b = 1'b1;
    src_addr = 16'h0; src_seg = 16'h0; dst_addr = 16'h0; dst_seg = 16'h0; len = 16'h0;
    pre_we = 1'b0; pre_idx = 12'h0; pre_data = 16'h0; mon_clr = 1'b1;
`ifdef MEMCPY_FILL_EN
    fill = 1'b0; fill_pattern = 16'h0000;
`endif
    repeat (3) tick();
    check_idle_outputs("reset");
    r = 1'b0;
    mon_clr = 1'b0;

    // Three-word copy, seg1:0000 -> seg2:0010.
    poke(12'h100, 16'hAAA1);
    poke(12'h101, 16'hAAA2);
    poke(12'h102, 16'hAAA3);
    go_a(16'h0000, 16'h0001, 16'h0010, 16'h0002, 16'd3);
    wait_a(lat, nbusy);
    check("copy3_latency", lat, 32'd8);
    check("copy3_busy_cycles", nbusy, 32'd8);
    tick();
    check("copy3_busy_after", {31'b0, busy_a}, 32'd0);
    check("copy3_w0", {16'b0, mem[12'h210]}, 32'hAAA1);
    check("copy3_w1", {16'b0, mem[12'h211]}, 32'hAAA2);
    check("copy3_w2", {16'b0, mem[12'h212]}, 32'hAAA3);

    // Zero-length copy: done next cycle, no bus activity.
    clear_mon();
    go_a(16'h0000, 16'h0001, 16'h0010, 16'h0002, 16'd0);
    wait_a(lat, nbusy);
    check("len0_latency", lat, 32'd1);
    tick();
    check("len0_bus_req", n_breq, 32'd0);
    check("len0_roe", n_roe, 32'd0);
    check("len0_rwe", n_rwe, 32'd0);
    check("len0_mem", {16'b0, mem[12'h210]}, 32'hAAA1);

    // Grant dropped for 3 cycles during the write of word 2 of 4.
    poke(12'h120, 16'h1111);
    poke(12'h121, 16'h2222);
    poke(12'h122, 16'h3333);
    poke(12'h123, 16'h4444);
    clear_mon();
    w0 = wcnt[12'h241];
    go_a(16'h0020, 16'h0001, 16'h0040, 16'h0002, 16'd4);
    repeat (4) tick();
    check("drop_in_write2", {31'b0, rwe_a}, 32'd1);
    grant_a = 1'b0;
    #1;
    check("drop_rwe_low", {31'b0, rwe_a}, 32'd0);
    repeat (3) tick();
    grant_a = 1'b1;
    wait_a(lat, nbusy);
    tick();
    check("drop_bad_cycles", n_bad, 32'd0);
    check("drop_w1_once", wcnt[12'h241] - w0, 32'd1);
    check("drop_w0", {16'b0, mem[12'h240]}, 32'h1111);
    check("drop_w1", {16'b0, mem[12'h241]}, 32'h2222);
    check("drop_w2", {16'b0, mem[12'h242]}, 32'h3333);
    check("drop_w3", {16'b0, mem[12'h243]}, 32'h4444);

    // Burst limit of 2 on dut_b: yields after words 2 and 4.
    clear_mon();
    src_addr = 16'h0000; src_seg = 16'h0001; dst_addr = 16'h0000; dst_seg = 16'h0004; len = 16'd5;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 200) begin
      tick();
      lat++;
    end
    check("burst_done_seen", {31'b0, done_b}, 32'd1);
    tick();
    check("burst_yields", n_yield, 32'd2);
    check("burst_yield1_after", y_at[0], 32'd2);
    check("burst_yield2_after", y_at[1], 32'd4);
    check("burst_words", nwr_b, 32'd5);

    // Destination offset wraps within the segment.
    go_a(16'h0000, 16'h0001, 16'hFFFF, 16'h0002, 16'd2);
    wait_a(lat, nbusy);
    tick();
    check("wrap_w0", {16'b0, mem[12'h1FF]}, 32'hAAA1);
    check("wrap_w1", {16'b0, mem[12'h200]}, 32'hAAA2);

    // Reset during the read of word 3 of 6.
    go_a(16'h0000, 16'h0001, 16'h0000, 16'h0003, 16'd6);
    repeat (5) tick();
    check("rst_in_read3_roe", {31'b0, roe_a}, 32'd1);
    check("rst_in_read3_addr", {16'b0, addr_a}, 32'h0002);
    r = 1'b1;
    tick();
    check_idle_outputs("midreset");
    r = 1'b0;
    go_a(16'h0000, 16'h0001, 16'h0020, 16'h0003, 16'd1);
    wait_a(lat, nbusy);
    check("after_rst_latency", lat, 32'd4);
    tick();
    check("after_rst_w0", {16'b0, mem[12'h320]}, 32'hAAA1);

`ifdef MEMCPY_FILL_EN
    fill = 1'b1;
    fill_pattern = 16'h5A5A;
    go_a(16'h0000, 16'h0001, 16'h0040, 16'h0003, 16'd4);
    fill = 1'b0;
    wait_a(lat, nbusy);
    check("fill_latency", lat, 32'd6);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("fill_word", {16'b0, mem[12'h340 + 12'(i)]}, 32'h5A5A);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
